// File: rtl/fanout_load_checker.sv
// Snapshots the high-fanout load bank on request, flags any disagreement between loads,
// and streams the snapshot out as fixed-width beats over a valid/ready port.
module fanout_load_checker #(
    parameter int NUM_LOADS = 150,
    parameter int BEAT_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic                 clk1,
    input  logic                 rst_n,
    input  logic [NUM_LOADS-1:0] load_q,
    input  logic                 capture_req,
    output logic                 capture_ack,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BEAT_W-1:0]    out_data,
    output logic                 out_last,
    output logic                 mismatch,
    output logic [CNT_W-1:0]     mismatch_cnt
);

    localparam int NBEATS = (NUM_LOADS + BEAT_W - 1) / BEAT_W;
    localparam int BIDX_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int PAD_W  = NBEATS * BEAT_W;
    localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(NBEATS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t               state_reg;
    logic [NUM_LOADS-1:0] shadow_reg;
    logic [BIDX_W-1:0]    idx_reg;
    logic                 ack_reg;
    logic                 mismatch_reg;
    logic [CNT_W-1:0]     cnt_reg;

    logic [PAD_W-1:0]     shadow_pad;
    logic [BEAT_W-1:0]    beat_mux [NBEATS];
    logic                 snap_mismatch;
    logic                 is_last;
    logic                 in_shift;

    // Zero-extend so bits beyond the last load read back as 0 in the final beat.
    assign shadow_pad = PAD_W'(shadow_reg);

    for (genvar gi = 0; gi < NBEATS; gi++) begin : g_beat
        assign beat_mux[gi] = shadow_pad[gi*BEAT_W +: BEAT_W];
    end

    // All loads share one D net, so any snapshot that is not uniform is a fault.
    assign snap_mismatch = ~(&load_q | ~|load_q);
    assign is_last       = (idx_reg == LAST_IDX);
    assign in_shift      = (state_reg == SHIFT);

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            shadow_reg   <= '0;
            idx_reg      <= '0;
            ack_reg      <= 1'b0;
            mismatch_reg <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            ack_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (capture_req) begin
                        shadow_reg   <= load_q;
                        mismatch_reg <= snap_mismatch;
                        if (snap_mismatch && (cnt_reg != CNT_MAX)) begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                        ack_reg   <= 1'b1;
                        idx_reg   <= '0;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (out_ready) begin
                        if (is_last) begin
                            idx_reg   <= '0;
                            state_reg <= IDLE;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign capture_ack  = ack_reg;
    assign busy         = in_shift;
    assign out_valid    = in_shift;
    assign out_last     = in_shift & is_last;
    assign out_data     = in_shift ? beat_mux[idx_reg] : '0;
    assign mismatch     = mismatch_reg;
    assign mismatch_cnt = cnt_reg;

endmodule

// File: tb/tb_fanout_load_checker.sv
// Directed bench for fanout_load_checker: expected beats are queued at capture
// time from a bit-level model and popped as the DUT transfers them.
module tb_fanout_load_checker;

    localparam int NL     = 150;
    localparam int BW     = 8;
    localparam int NBEATS = 19;

    logic          clk1;
    logic          rst_n;
    logic [NL-1:0] load_q;
    logic          capture_req;
    logic          capture_ack;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;
    logic          out_last;
    logic          mismatch;
    logic [15:0]   mismatch_cnt;

    logic [NL-1:0] s_load;
    logic          s_req;
    logic          s_ack;
    logic          s_busy;
    logic          s_valid;
    logic          s_ready;
    logic [BW-1:0] s_data;
    logic          s_last;
    logic          s_mism;
    logic [1:0]    s_cnt;

    fanout_load_checker #(.NUM_LOADS(NL), .BEAT_W(BW), .CNT_W(16)) dut (
        .clk1(clk1), .rst_n(rst_n), .load_q(load_q), .capture_req(capture_req),
        .capture_ack(capture_ack), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .mismatch(mismatch), .mismatch_cnt(mismatch_cnt)
    );

    fanout_load_checker #(.NUM_LOADS(NL), .BEAT_W(BW), .CNT_W(2)) dut_sat (
        .clk1(clk1), .rst_n(rst_n), .load_q(s_load), .capture_req(s_req),
        .capture_ack(s_ack), .busy(s_busy), .out_valid(s_valid),
        .out_ready(s_ready), .out_data(s_data), .out_last(s_last),
        .mismatch(s_mism), .mismatch_cnt(s_cnt)
    );

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    int n_vec  = 0;
    int n_fail = 0;
    int ack_count = 0;
    int exp_acks  = 0;
    int exp_cnt   = 0;
    logic exp_mism = 1'b0;
    logic [8:0] exp_q [$];

    always @(negedge clk1) begin
        if (capture_ack) ack_count <= ack_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_beat(input logic [NL-1:0] v, input int b);
        logic [7:0] r;
        r = '0;
        for (int k = 0; k < BW; k++) begin
            if (b*BW + k < NL) r[k] = v[b*BW + k];
        end
        return r;
    endfunction

    task automatic push_snapshot(input logic [NL-1:0] v);
        logic all1;
        logic all0;
        all1 = (v == {NL{1'b1}});
        all0 = (v == '0);
        exp_mism = !(all1 || all0);
        if (exp_mism && exp_cnt < 65535) exp_cnt++;
        for (int b = 0; b < NBEATS; b++) begin
            exp_q.push_back({(b == NBEATS-1), model_beat(v, b)});
        end
        exp_acks++;
    endtask

    // Called at a sample point with the DUT idle; returns at the sample point after the capture edge.
    task automatic capture(input logic [NL-1:0] v, input bit hold_req);
        load_q = v;
        capture_req = 1'b1;
        @(posedge clk1); #1;
        if (!hold_req) capture_req = 1'b0;
        push_snapshot(v);
        check("ack", 32'(capture_ack), 32'd1);
        check("busy", 32'(busy), 32'd1);
        check("mismatch", 32'(mismatch), 32'(exp_mism));
        check("cnt", 32'(mismatch_cnt), 32'(exp_cnt));
        $display("capture: mismatch=%0d cnt=%0d", mismatch, mismatch_cnt);
    endtask

    task automatic drain(input bit toggle, output int edges);
        logic [8:0] e;
        logic [7:0] hold_d;
        logic       hold_l;
        bit         stalled;
        stalled = 0;
        hold_d = '0;
        hold_l = 1'b0;
        edges = 0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && edges < 200) begin
            if (stalled) begin
                check("stall_data", 32'(out_data), 32'(hold_d));
                check("stall_last", 32'(out_last), 32'(hold_l));
            end
            stalled = 0;
            check("valid", 32'(out_valid), 32'd1);
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                check("beat_data", 32'(out_data), 32'(e[7:0]));
                check("beat_last", 32'(out_last), 32'(e[8]));
                $display("beat %0d: data=%02h last=%0d", NBEATS-1-exp_q.size(), out_data, out_last);
            end else if (out_valid) begin
                hold_d = out_data;
                hold_l = out_last;
                stalled = 1;
            end
            @(posedge clk1); #1;
            edges++;
            if (toggle) out_ready = ~out_ready;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        check("valid_after_last", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
    endtask

    initial begin
        int edges;
        logic [NL-1:0] v;
        logic [NL-1:0] pat;
        logic [8:0]    e;

        rst_n = 1'b0;
        load_q = '0;
        capture_req = 1'b0;
        out_ready = 1'b0;
        s_load = '0;
        s_req = 1'b0;
        s_ready = 1'b1;
        pat = {5{32'hA5C3_96E1}};

        #2;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack", 32'(capture_ack), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_mismatch", 32'(mismatch), 32'd0);
        check("rst_cnt", 32'(mismatch_cnt), 32'd0);
        @(posedge clk1); #1;
        rst_n = 1'b1;
        @(posedge clk1); #1;
        check("idle_valid", 32'(out_valid), 32'd0);

        // 1: uniform ones
        out_ready = 1'b1;
        capture({NL{1'b1}}, 1'b0);
        drain(1'b0, edges);
        check("t1_edges", 32'(edges), 32'(NBEATS));

        // 2: single disagreeing load at bit 77
        v = {NL{1'b1}};
        v[77] = 1'b0;
        capture(v, 1'b0);
        drain(1'b0, edges);

        // 3: ready toggling; load_q moves during SHIFT without effect
        capture(pat, 1'b0);
        load_q = ~pat;
        drain(1'b1, edges);
        check("t3_edges", 32'(edges), 32'(2*NBEATS-1));
        check("t3_cnt", 32'(mismatch_cnt), 32'(exp_cnt));

        // 4: request held high through the whole SHIFT
        capture('0, 1'b1);
        drain(1'b0, edges);
        check("t4_single_ack", 32'(ack_count), 32'(exp_acks));
        @(posedge clk1); #1;
        capture_req = 1'b0;
        push_snapshot(load_q);
        check("t4_second_ack", 32'(capture_ack), 32'd1);
        drain(1'b0, edges);
        check("t4_ack_total", 32'(ack_count), 32'(exp_acks));

        // 5: reset after beat 5 accepted, then clean restart at beat 0
        capture(pat, 1'b0);
        for (int i = 0; i < 6; i++) begin
            e = exp_q.pop_front();
            check("t5_pre_data", 32'(out_data), 32'(e[7:0]));
            @(posedge clk1); #1;
        end
        rst_n = 1'b0;
        #1;
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_cnt", 32'(mismatch_cnt), 32'd0);
        check("t5_mismatch", 32'(mismatch), 32'd0);
        $display("reset mid-shift: valid=%0d busy=%0d cnt=%0d", out_valid, busy, mismatch_cnt);
        exp_q.delete();
        exp_cnt = 0;
        exp_mism = 1'b0;
        @(posedge clk1); #1;
        rst_n = 1'b1;
        @(posedge clk1); #1;
        capture(pat, 1'b0);
        drain(1'b0, edges);

        // 6: 2-bit counter saturates
        for (int n = 0; n < 4; n++) begin
            s_load = pat;
            s_req = 1'b1;
            @(posedge clk1); #1;
            s_req = 1'b0;
            check("t6_sat_cnt", 32'(s_cnt), 32'((n + 1 > 3) ? 3 : n + 1));
            $display("sat capture %0d: cnt=%0d", n, s_cnt);
            repeat (NBEATS) @(posedge clk1);
            #1;
            check("t6_idle", 32'(s_valid), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
